// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-RAM req/ack access with byte/half/word lane formatting and pipeline stall.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  resetIn,
    input  logic                  memOpValid,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_W-1:0]     addrIn,
    input  logic [DATA_W-1:0]     storeDataIn,
    input  logic [DATA_W-1:0]     aluResultIn,
    input  logic                  writeEnableIn,
    input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
    output logic                  ramReq,
    output logic                  ramWe,
    output logic [DATA_W-1:0]     ramAddr,
    output logic [DATA_W-1:0]     ramWdata,
    output logic [3:0]            ramByteEn,
    input  logic                  ramAck,
    input  logic [DATA_W-1:0]     ramRdata,
    output logic                  stallOut,
    output logic                  busErrOut,
    output logic                  misalignOut,
    output logic                  select,
    output logic [DATA_W-1:0]     dataFromALU,
    output logic [DATA_W-1:0]     dataFromRam,
    output logic                  writeEnableOut,
    output logic [REG_ADDR_W-1:0] writeBackAddrOut
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [1:0]  SZ_B  = 2'd0;
    localparam logic [1:0]  SZ_H  = 2'd1;
    localparam logic [1:0]  SZ_W  = 2'd2;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [1:0]            lat_size, lat_size_d;
    logic                  lat_uns, lat_uns_d;
    logic [1:0]            lat_off, lat_off_d;
    logic                  lat_we, lat_we_d;
    logic [REG_ADDR_W-1:0] lat_rd, lat_rd_d;

    logic                  ram_req_d, ram_we_d, bus_err_d, misalign_d, select_d, we_out_d;
    logic [DATA_W-1:0]     ram_addr_d, ram_wdata_d, alu_d, ram_data_d;
    logic [3:0]            ram_be_d;
    logic [REG_ADDR_W-1:0] wb_addr_d;

    logic                  mem_op_c, aligned_c;
    logic [1:0]            size_c;
    logic [3:0]            be_c;
    logic [DATA_W-1:0]     wdata_c, load_c;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;

    assign mem_op_c = memOpValid & (memRead | memWrite);
    assign size_c   = funct3[1] ? SZ_W : {1'b0, funct3[0]};

`ifdef MISALIGN_TRAP_EN
    assign aligned_c = (size_c == SZ_H) ? ~addrIn[0] :
                       (size_c == SZ_W) ? (addrIn[1:0] == 2'b00) : 1'b1;
`else
    assign aligned_c = 1'b1;
`endif

    // Store lane enables and lane-replicated write data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = storeDataIn;
        case (size_c)
            SZ_B: begin
                be_c    = 4'b0001 << addrIn[1:0];
                wdata_c = {4{storeDataIn[7:0]}};
            end
            SZ_H: begin
                be_c    = addrIn[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{storeDataIn[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension using the latched access shape
    always_comb begin
        lane_b = ramRdata[7:0];
        case (lat_off)
            2'd1:    lane_b = ramRdata[15:8];
            2'd2:    lane_b = ramRdata[23:16];
            2'd3:    lane_b = ramRdata[31:24];
            default: ;
        endcase
        lane_h = lat_off[1] ? ramRdata[31:16] : ramRdata[15:0];
        load_c = ramRdata;
        case (lat_size)
            SZ_B:    load_c = {{(DATA_W-8){~lat_uns & lane_b[7]}}, lane_b};
            SZ_H:    load_c = {{(DATA_W-16){~lat_uns & lane_h[15]}}, lane_h};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_size_d  = lat_size;
        lat_uns_d   = lat_uns;
        lat_off_d   = lat_off;
        lat_we_d    = lat_we;
        lat_rd_d    = lat_rd;
        ram_req_d   = ramReq;
        ram_we_d    = ramWe;
        ram_addr_d  = ramAddr;
        ram_wdata_d = ramWdata;
        ram_be_d    = ramByteEn;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;
        select_d    = select;
        alu_d       = dataFromALU;
        ram_data_d  = dataFromRam;
        we_out_d    = writeEnableOut;
        wb_addr_d   = writeBackAddrOut;
        stallOut    = 1'b0;

        case (state)
            IDLE: begin
                if (mem_op_c && aligned_c) begin
                    stallOut    = 1'b1;
                    state_d     = WAIT;
                    cnt_d       = '0;
                    lat_size_d  = size_c;
                    lat_uns_d   = funct3[2];
                    lat_off_d   = addrIn[1:0];
                    lat_we_d    = writeEnableIn;
                    lat_rd_d    = writeBackAddrIn;
                    ram_req_d   = 1'b1;
                    ram_we_d    = memWrite & ~memRead;
                    ram_addr_d  = {addrIn[DATA_W-1:2], 2'b00};
                    ram_wdata_d = wdata_c;
                    ram_be_d    = be_c;
                    we_out_d    = 1'b0;
                end else if (mem_op_c) begin
                    misalign_d = 1'b1;
                    we_out_d   = 1'b0;
                end else begin
                    select_d  = 1'b1;
                    alu_d     = aluResultIn;
                    we_out_d  = writeEnableIn & memOpValid;
                    wb_addr_d = writeBackAddrIn;
                end
            end
            WAIT: begin
                stallOut = 1'b1;
                we_out_d = 1'b0;
                // An ack in the expiry cycle takes priority over the abort
                if (ramAck) begin
                    ram_req_d = 1'b0;
                    state_d   = IDLE;
                    wb_addr_d = lat_rd;
                    if (ramWe) begin
                        select_d   = 1'b1;
                        ram_data_d = '0;
                    end else begin
                        select_d   = 1'b0;
                        ram_data_d = load_c;
                        we_out_d   = lat_we;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    ram_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            state            <= IDLE;
            cnt              <= '0;
            lat_size         <= SZ_W;
            lat_uns          <= 1'b0;
            lat_off          <= 2'b00;
            lat_we           <= 1'b0;
            lat_rd           <= '0;
            ramReq           <= 1'b0;
            ramWe            <= 1'b0;
            ramAddr          <= '0;
            ramWdata         <= '0;
            ramByteEn        <= 4'b0000;
            busErrOut        <= 1'b0;
            misalignOut      <= 1'b0;
            select           <= 1'b1;
            dataFromALU      <= '0;
            dataFromRam      <= '0;
            writeEnableOut   <= 1'b0;
            writeBackAddrOut <= '0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            lat_size         <= lat_size_d;
            lat_uns          <= lat_uns_d;
            lat_off          <= lat_off_d;
            lat_we           <= lat_we_d;
            lat_rd           <= lat_rd_d;
            ramReq           <= ram_req_d;
            ramWe            <= ram_we_d;
            ramAddr          <= ram_addr_d;
            ramWdata         <= ram_wdata_d;
            ramByteEn        <= ram_be_d;
            busErrOut        <= bus_err_d;
            misalignOut      <= misalign_d;
            select           <= select_d;
            dataFromALU      <= alu_d;
            dataFromRam      <= ram_data_d;
            writeEnableOut   <= we_out_d;
            writeBackAddrOut <= wb_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level reference model plus directed and random stimulus.
module tb_mem_access_stage;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned TIMEOUT_CYC = 16;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetIn = 1'b0;
    logic        memOpValid = 1'b0, memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addrIn = '0, storeDataIn = '0, aluResultIn = '0;
    logic        writeEnableIn = 1'b0;
    logic [4:0]  writeBackAddrIn = '0;
    logic        ramAck = 1'b0;
    logic [31:0] ramRdata = '0;

    logic        ramReq, ramWe, stallOut, busErrOut, misalignOut, select, writeEnableOut;
    logic [31:0] ramAddr, ramWdata, dataFromALU, dataFromRam;
    logic [3:0]  ramByteEn;
    logic [4:0]  writeBackAddrOut;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .resetIn(resetIn), .memOpValid(memOpValid), .memRead(memRead),
        .memWrite(memWrite), .funct3(funct3), .addrIn(addrIn), .storeDataIn(storeDataIn),
        .aluResultIn(aluResultIn), .writeEnableIn(writeEnableIn), .writeBackAddrIn(writeBackAddrIn),
        .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata),
        .ramByteEn(ramByteEn), .ramAck(ramAck), .ramRdata(ramRdata), .stallOut(stallOut),
        .busErrOut(busErrOut), .misalignOut(misalignOut), .select(select),
        .dataFromALU(dataFromALU), .dataFromRam(dataFromRam), .writeEnableOut(writeEnableOut),
        .writeBackAddrOut(writeBackAddrOut)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access-shape arithmetic straight from the encoding rules
    function automatic int nbytes(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic bit trap_mis(input logic [2:0] f3, input logic [31:0] a);
        return TRAP_EN && ((a % 32'(nbytes(f3))) != 0);
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << nbytes(f3)) - 1) << lane_off(f3, a));
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] r, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v, mask;
        int n;
        n    = nbytes(f3);
        v    = r >> (8 * lane_off(f3, a));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model state: pending transaction and expected registered outputs
    bit          m_busy = 0;
    int          m_wait = 0;
    logic        p_store = 0, p_we = 0;
    logic [2:0]  p_f3 = '0;
    logic [31:0] p_addr = '0;
    logic [4:0]  p_rd = '0;
    logic        e_req = 0, e_rwe = 0, e_buserr = 0, e_mis = 0, e_weo = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_alu = '0, e_ram = '0;
    logic [3:0]  e_be = '0;
    logic [4:0]  e_wba = '0;
    bit          chk_pass = 1, chk_load = 0, chk_store = 1;

    task automatic model_reset();
        m_busy = 0; m_wait = 0;
        e_req = 0; e_buserr = 0; e_mis = 0; e_weo = 0;
        e_alu = '0; e_ram = '0; e_wba = '0;
        chk_pass = 1; chk_load = 0; chk_store = 1;
    endtask

    task automatic model_step();
        e_buserr = 0; e_mis = 0;
        chk_pass = 0; chk_load = 0; chk_store = 0;
        if (!m_busy) begin
            if (memOpValid && (memRead || memWrite)) begin
                if (trap_mis(funct3, addrIn)) begin
                    e_mis = 1; e_weo = 0;
                end else begin
                    m_busy = 1; m_wait = 0;
                    p_store = memWrite && !memRead;
                    p_f3 = funct3; p_addr = addrIn; p_we = writeEnableIn; p_rd = writeBackAddrIn;
                    e_req = 1; e_rwe = p_store;
                    e_addr = addrIn & 32'hFFFF_FFFC;
                    e_wdata = store_data(funct3, storeDataIn);
                    e_be = store_be(funct3, addrIn);
                    e_weo = 0;
                end
            end else begin
                chk_pass = 1;
                e_alu = aluResultIn;
                e_weo = writeEnableIn && memOpValid;
                e_wba = writeBackAddrIn;
            end
        end else begin
            m_wait++;
            e_weo = 0;
            if (ramAck) begin
                m_busy = 0; e_req = 0; e_wba = p_rd;
                if (p_store) begin
                    chk_store = 1; e_ram = '0;
                end else begin
                    chk_load = 1;
                    e_ram = load_fmt(ramRdata, p_f3, p_addr);
                    e_weo = p_we;
                end
            end else if (m_wait == int'(TIMEOUT_CYC)) begin
                m_busy = 0; e_req = 0; e_buserr = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge resetIn);
            if (resetIn) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("ramReq", 32'(ramReq), 32'(e_req));
            check("busErrOut", 32'(busErrOut), 32'(e_buserr));
            check("misalignOut", 32'(misalignOut), 32'(e_mis));
            check("writeEnableOut", 32'(writeEnableOut), 32'(e_weo));
            check("stallOut", 32'(stallOut),
                  32'(m_busy || (memOpValid && (memRead || memWrite) && !trap_mis(funct3, addrIn))));
            if (e_req) begin
                check("ramWe", 32'(ramWe), 32'(e_rwe));
                check("ramAddr", ramAddr, e_addr);
                if (e_rwe) begin
                    check("ramByteEn", 32'(ramByteEn), 32'(e_be));
                    check("ramWdata", ramWdata, e_wdata);
                end
            end
            if (chk_pass) begin
                check("pass_select", 32'(select), 32'd1);
                check("pass_dataFromALU", dataFromALU, e_alu);
                check("pass_wbAddr", 32'(writeBackAddrOut), 32'(e_wba));
            end
            if (chk_load) begin
                check("load_select", 32'(select), 32'd0);
                check("load_dataFromRam", dataFromRam, e_ram);
                check("load_wbAddr", 32'(writeBackAddrOut), 32'(e_wba));
            end
            if (chk_store) check("store_dataFromRam", dataFromRam, e_ram);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        memOpValid = 0; memRead = 0; memWrite = 0; ramAck = 0;
        writeEnableIn = 0;
    endtask

    task automatic timeout_run(input bit ack_last);
        set_idle();
        memOpValid = 1; memRead = 1; funct3 = 3'b010; addrIn = 32'h200;
        writeEnableIn = 1; writeBackAddrIn = 5'd9;
        tick();
        set_idle();
        for (int i = 1; i <= int'(TIMEOUT_CYC); i++) begin
            check("to_req_held", 32'(ramReq), 32'd1);
            ramAck = ack_last && (i == int'(TIMEOUT_CYC));
            ramRdata = 32'hCAFE_0001;
            tick();
        end
        set_idle();
        check("to_busErr", 32'(busErrOut), ack_last ? 32'd0 : 32'd1);
        check("to_req_off", 32'(ramReq), 32'd0);
        check("to_weo", 32'(writeEnableOut), ack_last ? 32'd1 : 32'd0);
        if (ack_last) check("to_data", dataFromRam, 32'hCAFE_0001);
        tick();
        check("to_busErr_pulse", 32'(busErrOut), 32'd0);
        check("to_idle_stall", 32'(stallOut), 32'd0);
    endtask

    int stall_cnt;

    initial begin
        // Pin the model's lane arithmetic with hand-computed values
        check("pin_lb", load_fmt(32'h80FF_FF00, 3'b000, 32'h103), 32'hFFFF_FF80);
        check("pin_hu", load_fmt(32'h8001_1234, 3'b101, 32'h102), 32'h0000_8001);
        check("pin_sh_be", 32'(store_be(3'b001, 32'h102)), 32'h0000_000C);
        check("pin_sb_data", store_data(3'b000, 32'h1234_56A5), 32'hA5A5_A5A5);

        set_idle();
        #1 resetIn = 1;
        repeat (2) @(posedge clk);
        #2 resetIn = 0;
        check("rst_select", 32'(select), 32'd1);
        check("rst_ramReq", 32'(ramReq), 32'd0);
        check("rst_dataFromRam", dataFromRam, 32'd0);

        // ALU pass-through
        set_idle();
        memOpValid = 1; aluResultIn = 32'h1234; writeEnableIn = 1; writeBackAddrIn = 5'd5;
        #1 check("alu_stall", 32'(stallOut), 32'd0);
        tick();
        set_idle();
        check("alu_select", 32'(select), 32'd1);
        check("alu_data", dataFromALU, 32'h1234);
        check("alu_we", 32'(writeEnableOut), 32'd1);
        check("alu_rd", 32'(writeBackAddrOut), 32'd5);

        // LB 0x103 with ack in the third wait cycle
        set_idle();
        memOpValid = 1; memRead = 1; funct3 = 3'b000; addrIn = 32'h103;
        writeEnableIn = 1; writeBackAddrIn = 5'd7;
        stall_cnt = 0;
        #1 if (stallOut) stall_cnt++;
        tick();
        set_idle();
        for (int i = 1; i <= 3; i++) begin
            ramAck = (i == 3);
            ramRdata = (i == 3) ? 32'h80FF_FF00 : $urandom;
            #1 if (stallOut) stall_cnt++;
            check("lb_req", 32'(ramReq), 32'd1);
            tick();
        end
        set_idle();
        check("lb_data", dataFromRam, 32'hFFFF_FF80);
        check("lb_select", 32'(select), 32'd0);
        check("lb_we", 32'(writeEnableOut), 32'd1);
        for (int i = 0; i < 2; i++) begin
            #1 if (stallOut) stall_cnt++;
            tick();
        end
        check("lb_stall_cycles", 32'(stall_cnt), 32'd4);

        // SH 0x102
        set_idle();
        memOpValid = 1; memWrite = 1; funct3 = 3'b001; addrIn = 32'h102;
        storeDataIn = 32'h5555_ABCD; writeEnableIn = 1;
        tick();
        set_idle();
        check("sh_be", 32'(ramByteEn), 32'h0000_000C);
        check("sh_wdata", ramWdata, 32'hABCD_ABCD);
        check("sh_addr", ramAddr, 32'h100);
        check("sh_we", 32'(ramWe), 32'd1);
        check("sh_weo_bubble", 32'(writeEnableOut), 32'd0);
        ramAck = 1;
        tick();
        set_idle();
        check("sh_done_req", 32'(ramReq), 32'd0);
        check("sh_done_weo", 32'(writeEnableOut), 32'd0);

        timeout_run(1'b0);
        timeout_run(1'b1);

        // Reset asserted mid-wait
        set_idle();
        memOpValid = 1; memRead = 1; funct3 = 3'b010; addrIn = 32'h300;
        tick();
        set_idle();
        check("rw_req_before", 32'(ramReq), 32'd1);
        #1 resetIn = 1;
        #1;
        check("rw_req", 32'(ramReq), 32'd0);
        check("rw_select", 32'(select), 32'd1);
        check("rw_weo", 32'(writeEnableOut), 32'd0);
        check("rw_alu", dataFromALU, 32'd0);
        check("rw_stall", 32'(stallOut), 32'd0);
        @(posedge clk);
        #2 resetIn = 0;

        // LW 0x101
        set_idle();
        memOpValid = 1; memRead = 1; funct3 = 3'b010; addrIn = 32'h101; writeEnableIn = 1;
`ifdef MISALIGN_TRAP_EN
        #1 check("lw_mis_stall", 32'(stallOut), 32'd0);
        tick();
        set_idle();
        check("lw_mis_pulse", 32'(misalignOut), 32'd1);
        check("lw_mis_req", 32'(ramReq), 32'd0);
        tick();
        check("lw_mis_clear", 32'(misalignOut), 32'd0);
        check("lw_mis_req2", 32'(ramReq), 32'd0);
`else
        tick();
        set_idle();
        check("lw_req", 32'(ramReq), 32'd1);
        check("lw_addr", ramAddr, 32'h100);
        ramAck = 1; ramRdata = 32'hDEAD_BEEF;
        tick();
        set_idle();
        check("lw_data", dataFromRam, 32'hDEAD_BEEF);
        check("lw_mis", 32'(misalignOut), 32'd0);
`endif

        // Randomized traffic: frequent acks, then sparse acks to provoke timeouts
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 400; i++) begin
                memOpValid      = ($urandom_range(0, 3) != 0);
                memRead         = 1'($urandom_range(0, 1));
                memWrite        = 1'($urandom_range(0, 1));
                funct3          = 3'($urandom);
                addrIn          = $urandom;
                storeDataIn     = $urandom;
                aluResultIn     = $urandom;
                writeEnableIn   = 1'($urandom_range(0, 1));
                writeBackAddrIn = 5'($urandom);
                ramAck          = (phase == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
                ramRdata        = $urandom;
                tick();
            end
        end

        set_idle();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
